vga_sprite_commit: RTL and testbench
====================================

// Module: vga_sprite_commit
// PURPOSE
// - Bus initiator that drives the vga_top register port. Keeps a CPU-writable shadow of the ctrl word and the 32 sprite words.
// - On a commit command it polls the vga_top status register until vertical blank.
// - It then writes every dirty shadow word into vga_top in one tear-free back-to-back burst. The burst takes at most 33 cycles.
// PARAMETERS
// NUM_SPRITES   32   sprite words; the sprite window is vga_top addresses 0x20..0x3F
// VBLANK_FIRST  480  first vcount at which a burst may start
// VBLANK_LAST   520  last vcount at which a burst may start; leaves margin before the line-0 prefetch at 524
// POLL_GAP      16   idle cycles between successive status polls
// PORTS
// clk           in   1   system clock, 50 MHz
// reset         in   1   asynchronous, active-high
// s_chipselect  in   1   CPU-side slave select
// s_write       in   1   CPU-side write strobe (0 = read)
// s_address     in   6   0x00 ctrl shadow; 0x01 cmd/status; 0x20..0x3F sprite shadow
// s_writedata   in   32  CPU write data
// s_readdata    out  32  registered read data, valid 1 cycle after the read
// m_chipselect  out  1   to vga_top chipselect
// m_write       out  1   to vga_top write
// m_address     out  6   to vga_top address
// m_writedata   out  32  to vga_top writedata
// m_readdata    in   32  from vga_top readdata; registered there, valid 1 cycle after a read
// done_irq      out  1   one-cycle pulse when a burst completes
// BEHAVIOUR
// - Reset (async): outputs 0, FSM = IDLE, dirty mask = 0, pending = 0, commit count = 0. Shadow RAM contents are not reset.
// - CPU writes:
//   - 0x00 and 0x20+i update the shadow in 1 cycle and set the matching dirty bit (33 bits: ctrl + 32 sprites).
//   - 0x01 with bit0 = 1 is a commit.
// - CPU reads:
//   - 0x01 returns {commit_cnt[15:0], 14'b0, pending, busy}.
//   - 0x00 and 0x20+i return the shadow value.
//   - Any other address returns 0.
// - FSM:
//   - IDLE -> POLL_RD on commit, or on pending (clear pending).
//   - POLL_RD: 1 cycle; m_chipselect = 1, m_write = 0, m_address = 0x01 -> POLL_WT.
//   - POLL_WT: 1 cycle; m_chipselect = 0, sample v = m_readdata[9:0] on the next edge.
//     - VBLANK_FIRST <= v <= VBLANK_LAST: snapshot the dirty mask into xfer_mask, clear the dirty mask -> XFER.
//     - Otherwise -> GAP.
//   - GAP: count POLL_GAP cycles -> POLL_RD.
//   - XFER: one write per cycle, m_chipselect = m_write = 1.
//     - Sprites go first, lowest set bit of xfer_mask[32:1] first; address 0x20+i, data = shadow[i] read that cycle.
//     - The ctrl word (0x00) goes last if xfer_mask[0] is set.
//     - Clear each bit as it is issued. When the mask is empty -> DONE.
//     - An empty snapshot goes directly to DONE with no writes.
//   - DONE: 1 cycle; done_irq = 1, commit_cnt += 1 (wraps at 2^16) -> IDLE.
// - busy = 1 in every state except IDLE.
// - Commit while busy sets pending. Multiple pending commits collapse into one.
// - CPU write that lands in the same cycle as the dirty-mask snapshot: the set wins, so the entry stays dirty for the next commit.
// - CPU write to a shadow entry during XFER:
//   - Store the new value and set its dirty bit.
//   - If the entry has not yet been issued, the burst carries the new value. It is written again on the next commit.
// - m_* outputs are registered. m_address and m_writedata hold their last value when m_chipselect = 0.
// - Reset mid-burst: the bus releases immediately (async). The partial burst is dropped and the dirty mask is lost; software re-commits.
// - Worst-case burst of 33 writes is far shorter than one 1600-cycle line, so a burst never straddles the window end.
// STRUCTURE
// - vga_pkg holds:
//   - CTRL_ADDR = 6'h00, STATUS_ADDR = 6'h01, SPRITE_BASE = 6'h20
//   - STATUS_VCOUNT_MSB = 9
//   - typedef enum {IDLE, POLL_RD, POLL_WT, GAP, XFER, DONE} commit_state_t
// - Shadow store: 33x32 register array or an inferred dual-port RAM, with a combinational read at the issue index.
// - Sub-module sprite_dirty_pick: 32-bit mask -> {found, idx[4:0]} lowest-set-bit encoder; also used by the verification model.
// TESTING
// - Reset: after reset, all m_* = 0 and done_irq = 0; s_readdata of 0x01 = 0; no bus activity for 100 cycles.
// - Basic burst: write sprites 3 and 17, then commit.
//   - While the responder model returns vcount = 100: only polls at 0x01, spaced POLL_GAP + 2 cycles apart.
//   - When it returns 480: writes to 0x23 then 0x31 on consecutive cycles, no write to 0x00, then done_irq, commit_cnt = 1.
// - Ctrl only: write ctrl 0xE0000002, commit, vcount = 500 -> exactly one write (0x00, 0xE0000002), then done_irq.
// - Window edges: vcount = 522 -> polling continues with no writes. vcount = 479 -> no burst. vcount = 520 -> burst starts.
// - Commit and write during XFER: sprites 0..31 dirty, commit, then during XFER write sprite 0 and commit again.
//   - Pending reads 1.
//   - A second burst carries only 0x20 with the new value; commit_cnt = 2.
// - Async reset mid-XFER (after 5 writes): m_chipselect drops before the next edge, the FSM goes IDLE, and a new commit after reset issues no writes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and bus payload for the sprite commit engine.
package vga_pkg;

    localparam int unsigned NUM_SPRITES       = 32;
    localparam int unsigned NUM_WORDS         = NUM_SPRITES + 1;
    localparam int unsigned ADDR_W            = 6;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned IDX_W             = 5;
    localparam int unsigned WORD_W            = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W             = 16;
    localparam int unsigned STATUS_VCOUNT_MSB = 9;
    localparam int unsigned VCOUNT_W          = STATUS_VCOUNT_MSB + 1;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = 6'h00;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 6'h01;
    localparam logic [ADDR_W-1:0] SPRITE_BASE = 6'h20;

    typedef enum logic [2:0] {
        IDLE,
        POLL_RD,
        POLL_WT,
        GAP,
        XFER,
        DONE
    } commit_state_t;

    typedef struct packed {
        logic              cs;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } bus_req_t;

endpackage

// File: rtl/sprite_dirty_pick.sv
// Lowest-set-bit encoder over the sprite dirty mask.
module sprite_dirty_pick
    import vga_pkg::*;
(
    input  logic [NUM_SPRITES-1:0] mask,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        found = |mask;
        idx   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vga_sprite_commit.sv
// CPU-side shadow of the vga_top ctrl/sprite registers, flushed as one burst
// during vertical blank after a commit command.
module vga_sprite_commit
    import vga_pkg::*;
#(
    parameter int unsigned VBLANK_FIRST = 480,
    parameter int unsigned VBLANK_LAST  = 520,
    parameter int unsigned POLL_GAP     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_chipselect,
    input  logic              s_write,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              done_irq
);

    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

    commit_state_t        state, next_state;
    bus_req_t             m_req, m_req_n;
    logic [NUM_WORDS-1:0] dirty, dirty_n;
    logic [NUM_WORDS-1:0] xfer_mask, xfer_mask_n;
    logic                 pending, pending_n;
    logic [CNT_W-1:0]     commit_cnt, commit_cnt_n;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
    logic                 done_irq_n;
    logic                 busy;

    logic [DATA_W-1:0]    shadow [NUM_WORDS];

    logic                 cpu_wr, cpu_rd;
    logic                 hit_ctrl, hit_sprite, hit_status;
    logic                 commit_req;
    logic [WORD_W-1:0]    cpu_word;
    logic [NUM_WORDS-1:0] wr_mask;
    logic [DATA_W-1:0]    rd_data_c;

    logic                 spr_found;
    logic [IDX_W-1:0]     spr_idx;
    logic [WORD_W-1:0]    issue_word;
    logic [ADDR_W-1:0]    issue_addr;
    logic [NUM_WORDS-1:0] issue_bit;

    logic [VCOUNT_W-1:0]  vcount;
    logic                 in_window;
    logic                 unused_readdata;

    // CPU port decode; shadow word 0 is ctrl, words 1..32 are sprites 0..31
    assign cpu_wr     = s_chipselect & s_write;
    assign cpu_rd     = s_chipselect & ~s_write;
    assign hit_ctrl   = (s_address == CTRL_ADDR);
    assign hit_status = (s_address == STATUS_ADDR);
    assign hit_sprite = (s_address[ADDR_W-1:IDX_W] == SPRITE_BASE[ADDR_W-1:IDX_W]);
    assign commit_req = cpu_wr & hit_status & s_writedata[0];
    assign cpu_word   = hit_sprite ? WORD_W'(s_address[IDX_W-1:0]) + WORD_W'(1) : '0;
    assign wr_mask    = (cpu_wr & (hit_ctrl | hit_sprite)) ? NUM_WORDS'(1) << cpu_word : '0;

    assign busy = (state != IDLE);

    always_comb begin
        rd_data_c = '0;
        if (hit_status) begin
            rd_data_c = {commit_cnt, 14'b0, pending, busy};
        end else if (hit_ctrl || hit_sprite) begin
            rd_data_c = shadow[cpu_word];
        end
    end

    // Shadow store has no reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (cpu_wr && (hit_ctrl || hit_sprite)) begin
            shadow[cpu_word] <= s_writedata;
        end
    end

    sprite_dirty_pick u_pick (
        .mask  (xfer_mask[NUM_WORDS-1:1]),
        .found (spr_found),
        .idx   (spr_idx)
    );

    // Sprites drain lowest first; ctrl is issued only once no sprite remains.
    assign issue_word = spr_found ? WORD_W'(spr_idx) + WORD_W'(1) : '0;
    assign issue_addr = spr_found ? SPRITE_BASE + ADDR_W'(spr_idx) : CTRL_ADDR;
    assign issue_bit  = NUM_WORDS'(1) << issue_word;

    assign vcount          = m_readdata[STATUS_VCOUNT_MSB:0];
    assign in_window       = (vcount >= VCOUNT_W'(VBLANK_FIRST)) && (vcount <= VCOUNT_W'(VBLANK_LAST));
    assign unused_readdata = ^m_readdata[DATA_W-1:VCOUNT_W];

    always_comb begin
        next_state   = state;
        m_req_n      = m_req;
        m_req_n.cs   = 1'b0;
        m_req_n.write = 1'b0;
        dirty_n      = dirty | wr_mask;
        xfer_mask_n  = xfer_mask;
        pending_n    = pending;
        commit_cnt_n = commit_cnt;
        gap_cnt_n    = gap_cnt;
        done_irq_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (commit_req || pending) begin
                    next_state = POLL_RD;
                    pending_n  = 1'b0;
                end
            end
            POLL_RD: next_state = POLL_WT;
            POLL_WT: begin
                if (in_window) begin
                    // A CPU write in this same cycle stays dirty for the next commit.
                    xfer_mask_n = dirty;
                    dirty_n     = wr_mask;
                    next_state  = (dirty == '0) ? DONE : XFER;
                end else begin
                    gap_cnt_n  = '0;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                    next_state = POLL_RD;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            XFER: begin
                if (xfer_mask != '0) begin
                    m_req_n.cs        = 1'b1;
                    m_req_n.write     = 1'b1;
                    m_req_n.address   = issue_addr;
                    m_req_n.writedata = shadow[issue_word];
                    xfer_mask_n       = xfer_mask & ~issue_bit;
                end
                if (xfer_mask_n == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_irq_n   = 1'b1;
                commit_cnt_n = commit_cnt + CNT_W'(1);
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (commit_req && busy) begin
            pending_n = 1'b1;
        end

        // Status read is launched so it is on the bus for exactly the POLL_RD cycle.
        if (next_state == POLL_RD) begin
            m_req_n.cs      = 1'b1;
            m_req_n.write   = 1'b0;
            m_req_n.address = STATUS_ADDR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            m_req      <= '0;
            dirty      <= '0;
            xfer_mask  <= '0;
            pending    <= 1'b0;
            commit_cnt <= '0;
            gap_cnt    <= '0;
            done_irq   <= 1'b0;
            s_readdata <= '0;
        end else begin
            state      <= next_state;
            m_req      <= m_req_n;
            dirty      <= dirty_n;
            xfer_mask  <= xfer_mask_n;
            pending    <= pending_n;
            commit_cnt <= commit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            done_irq   <= done_irq_n;
            if (cpu_rd) begin
                s_readdata <= rd_data_c;
            end
        end
    end

    assign m_chipselect = m_req.cs;
    assign m_write      = m_req.write;
    assign m_address    = m_req.address;
    assign m_writedata  = m_req.writedata;

endmodule

// File: tb/tb_vga_sprite_commit.sv
// Bench for vga_sprite_commit: vga_top responder plus a dirty-set burst model.
module tb_vga_sprite_commit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_chipselect = 1'b0;
    logic        s_write = 1'b0;
    logic [5:0]  s_address = '0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        m_chipselect;
    logic        m_write;
    logic [5:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        done_irq;
    logic [9:0]  vcount = 10'd100;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [5:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          poll_cyc_q [$];
    logic [5:0]  poll_addr_q [$];

    logic [31:0] ref_shadow [33];
    logic [32:0] ref_dirty = '0;
    int          ref_cnt = 0;
    logic [5:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    vga_sprite_commit dut (
        .clk          (clk),
        .reset        (reset),
        .s_chipselect (s_chipselect),
        .s_write      (s_write),
        .s_address    (s_address),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .done_irq     (done_irq)
    );

    always #10 clk = ~clk;

    // vga_top responder and bus monitor
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_chipselect && m_write) begin
            wr_addr_q.push_back(m_address);
            wr_data_q.push_back(m_writedata);
            wr_cyc_q.push_back(cyc);
        end
        if (m_chipselect && !m_write) begin
            poll_cyc_q.push_back(cyc);
            poll_addr_q.push_back(m_address);
            m_readdata <= {22'd0, vcount};
        end
        if (done_irq) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
        int w;
        s_chipselect = 1'b1;
        s_write      = 1'b1;
        s_address    = a;
        s_writedata  = d;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write      = 1'b0;
        if (a == 6'h00) begin
            ref_shadow[0] = d;
            ref_dirty[0]  = 1'b1;
        end else if (a >= 6'h20) begin
            w = int'(a) - 32 + 1;
            ref_shadow[w] = d;
            ref_dirty[w]  = 1'b1;
        end
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
        s_chipselect = 1'b1;
        s_write      = 1'b0;
        s_address    = a;
        @(negedge clk);
        s_chipselect = 1'b0;
        d = s_readdata;
    endtask

    // Burst content: every dirty sprite in ascending order, then ctrl if dirty.
    task automatic build_expected();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < 32; i++) begin
            if (ref_dirty[i + 1]) begin
                exp_addr_q.push_back(6'(32 + i));
                exp_data_q.push_back(ref_shadow[i + 1]);
            end
        end
        if (ref_dirty[0]) begin
            exp_addr_q.push_back(6'h00);
            exp_data_q.push_back(ref_shadow[0]);
        end
        ref_dirty = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s_done_timeout: no done_irq within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int wb, pb;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (m_chipselect !== 1'b0) begin errors++; $display("FAIL rst_m_cs: got %b want 0", m_chipselect); end
        if (m_write !== 1'b0) begin errors++; $display("FAIL rst_m_write: got %b want 0", m_write); end
        if (m_address !== 6'h00) begin errors++; $display("FAIL rst_m_addr: got %h want 00", m_address); end
        if (m_writedata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata: got %h want 0", m_writedata); end
        if (done_irq !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_irq); end
        if (s_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", s_readdata); end
        reset = 1'b0;
        @(negedge clk);
        cpu_read(6'h01, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", d); end
        wb = wr_addr_q.size();
        pb = poll_cyc_q.size();
        repeat (100) @(negedge clk);
        checks += 2;
        if (wr_addr_q.size() != wb) begin errors++; $display("FAIL rst_quiet_wr: got %0d writes want 0", wr_addr_q.size() - wb); end
        if (poll_cyc_q.size() != pb) begin errors++; $display("FAIL rst_quiet_poll: got %0d polls want 0", poll_cyc_q.size() - pb); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int wb, pb, bad;
        vcount = 10'd100;
        wb = wr_addr_q.size();
        pb = poll_cyc_q.size();
        cpu_write(6'h23, $urandom);
        cpu_write(6'h31, $urandom);
        cpu_write(6'h01, 32'h1);
        build_expected();
        cpu_read(6'h01, d);
        checks++;
        if (d !== {16'(ref_cnt), 16'h0001}) begin errors++; $display("FAIL basic_busy: got %h want %h", d, {16'(ref_cnt), 16'h0001}); end
        repeat (60) @(negedge clk);
        bad = 0;
        for (int k = pb; k < poll_cyc_q.size(); k++) begin
            if (poll_addr_q[k] !== 6'h01) bad++;
            if (k > pb && poll_cyc_q[k] - poll_cyc_q[k - 1] != 18) bad++;
        end
        checks += 3;
        if (poll_cyc_q.size() - pb < 3) begin errors++; $display("FAIL basic_poll_cnt: got %0d polls want >=3", poll_cyc_q.size() - pb); end
        if (bad != 0) begin errors++; $display("FAIL basic_poll_shape: got %0d bad addr/spacing want 0", bad); end
        if (wr_addr_q.size() != wb) begin errors++; $display("FAIL basic_early_wr: got %0d writes want 0", wr_addr_q.size() - wb); end
        vcount = 10'd480;
        wait_done(100, "basic");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != exp_addr_q.size()) begin errors++; $display("FAIL basic_len: got %0d writes want %0d", wr_addr_q.size() - wb, exp_addr_q.size()); end
        for (int k = 0; k < exp_addr_q.size() && wb + k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wb + k] !== exp_addr_q[k] || wr_data_q[wb + k] !== exp_data_q[k]) begin
                errors++; $display("FAIL basic_wr%0d: got %h/%h want %h/%h", k, wr_addr_q[wb + k], wr_data_q[wb + k], exp_addr_q[k], exp_data_q[k]);
            end
        end
        if (wr_addr_q.size() - wb == 2) begin
            checks += 2;
            if (wr_cyc_q[wb + 1] != wr_cyc_q[wb] + 1) begin errors++; $display("FAIL basic_b2b: got gap %0d want 1", wr_cyc_q[wb + 1] - wr_cyc_q[wb]); end
            if (done_cyc <= wr_cyc_q[wb + 1]) begin errors++; $display("FAIL basic_done_order: got done cyc %0d last wr %0d", done_cyc, wr_cyc_q[wb + 1]); end
        end
        cpu_read(6'h01, d);
        checks++;
        if (d !== {16'(ref_cnt), 16'h0000}) begin errors++; $display("FAIL basic_status: got %h want %h", d, {16'(ref_cnt), 16'h0000}); end
    endtask

    task automatic test_ctrl_only();
        int wb;
        vcount = 10'd500;
        wb = wr_addr_q.size();
        cpu_write(6'h00, 32'hE000_0002);
        cpu_write(6'h01, 32'h1);
        build_expected();
        wait_done(100, "ctrl");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != 1) begin errors++; $display("FAIL ctrl_len: got %0d writes want 1", wr_addr_q.size() - wb); end
        if (wr_addr_q.size() - wb >= 1) begin
            checks++;
            if (wr_addr_q[wb] !== 6'h00 || wr_data_q[wb] !== 32'hE000_0002) begin
                errors++; $display("FAIL ctrl_wr: got %h/%h want 00/e0000002", wr_addr_q[wb], wr_data_q[wb]);
            end
        end
    endtask

    task automatic test_window_edges();
        int wb, pb;
        logic [31:0] v;
        v = $urandom;
        wb = wr_addr_q.size();
        vcount = 10'd522;
        cpu_write(6'h25, v);
        cpu_write(6'h01, 32'h1);
        build_expected();
        pb = poll_cyc_q.size();
        repeat (60) @(negedge clk);
        checks += 2;
        if (wr_addr_q.size() != wb) begin errors++; $display("FAIL win522_wr: got %0d writes want 0", wr_addr_q.size() - wb); end
        if (poll_cyc_q.size() - pb < 3) begin errors++; $display("FAIL win522_poll: got %0d polls want >=3", poll_cyc_q.size() - pb); end
        vcount = 10'd479;
        pb = poll_cyc_q.size();
        repeat (60) @(negedge clk);
        checks += 2;
        if (wr_addr_q.size() != wb) begin errors++; $display("FAIL win479_wr: got %0d writes want 0", wr_addr_q.size() - wb); end
        if (poll_cyc_q.size() - pb < 3) begin errors++; $display("FAIL win479_poll: got %0d polls want >=3", poll_cyc_q.size() - pb); end
        vcount = 10'd520;
        wait_done(60, "win520");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != 1) begin errors++; $display("FAIL win520_len: got %0d writes want 1", wr_addr_q.size() - wb); end
        if (wr_addr_q.size() - wb >= 1) begin
            checks++;
            if (wr_addr_q[wb] !== exp_addr_q[0] || wr_data_q[wb] !== exp_data_q[0]) begin
                errors++; $display("FAIL win520_wr: got %h/%h want %h/%h", wr_addr_q[wb], wr_data_q[wb], exp_addr_q[0], exp_data_q[0]);
            end
        end
    endtask

    task automatic test_write_during_xfer();
        logic [31:0] d;
        int wb, n;
        vcount = 10'd480;
        wb = wr_addr_q.size();
        for (int i = 0; i < 32; i++) cpu_write(6'(32 + i), $urandom);
        cpu_write(6'h01, 32'h1);
        build_expected();
        n = 0;
        while (wr_addr_q.size() < wb + 1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (wr_addr_q.size() < wb + 1) begin errors++; $display("FAIL xfer_start: got 0 writes want >=1"); end
        cpu_write(6'h20, $urandom);
        cpu_write(6'h01, 32'h1);
        cpu_read(6'h01, d);
        checks++;
        if (d[1:0] !== 2'b11) begin errors++; $display("FAIL xfer_pending: got pending/busy %b want 11", d[1:0]); end
        wait_done(100, "xfer1");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != exp_addr_q.size()) begin errors++; $display("FAIL xfer1_len: got %0d writes want %0d", wr_addr_q.size() - wb, exp_addr_q.size()); end
        for (int k = 0; k < exp_addr_q.size() && wb + k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wb + k] !== exp_addr_q[k] || wr_data_q[wb + k] !== exp_data_q[k] || wr_cyc_q[wb + k] != wr_cyc_q[wb] + k) begin
                errors++; $display("FAIL xfer1_wr%0d: got %h/%h want %h/%h", k, wr_addr_q[wb + k], wr_data_q[wb + k], exp_addr_q[k], exp_data_q[k]);
            end
        end
        wb = wr_addr_q.size();
        build_expected();
        wait_done(200, "xfer2");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != 1) begin errors++; $display("FAIL xfer2_len: got %0d writes want 1", wr_addr_q.size() - wb); end
        if (wr_addr_q.size() - wb >= 1) begin
            checks++;
            if (wr_addr_q[wb] !== exp_addr_q[0] || wr_data_q[wb] !== exp_data_q[0]) begin
                errors++; $display("FAIL xfer2_wr: got %h/%h want %h/%h", wr_addr_q[wb], wr_data_q[wb], exp_addr_q[0], exp_data_q[0]);
            end
        end
        cpu_read(6'h01, d);
        checks++;
        if (d !== {16'(ref_cnt), 16'h0000}) begin errors++; $display("FAIL xfer_cnt: got %h want %h", d, {16'(ref_cnt), 16'h0000}); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [31:0] d;
        int wb, n;
        vcount = 10'd480;
        wb = wr_addr_q.size();
        for (int i = 0; i < 32; i++) cpu_write(6'(32 + i), $urandom);
        cpu_write(6'h01, 32'h1);
        n = 0;
        while (wr_addr_q.size() < wb + 5 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (m_chipselect !== 1'b1) begin errors++; $display("FAIL rstx_pre_cs: got %b want 1", m_chipselect); end
        reset = 1'b1;
        #1;
        checks += 2;
        if (m_chipselect !== 1'b0) begin errors++; $display("FAIL rstx_cs: got %b want 0", m_chipselect); end
        if (m_write !== 1'b0) begin errors++; $display("FAIL rstx_write: got %b want 0", m_write); end
        @(negedge clk);
        reset = 1'b0;
        ref_dirty = '0;
        ref_cnt = 0;
        @(negedge clk);
        cpu_read(6'h01, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstx_status: got %h want 0", d); end
        wb = wr_addr_q.size();
        cpu_write(6'h01, 32'h1);
        build_expected();
        wait_done(100, "rstx");
        ref_cnt++;
        checks++;
        if (wr_addr_q.size() - wb != exp_addr_q.size()) begin errors++; $display("FAIL rstx_len: got %0d writes want %0d", wr_addr_q.size() - wb, exp_addr_q.size()); end
        cpu_read(6'h01, d);
        checks++;
        if (d !== {16'(ref_cnt), 16'h0000}) begin errors++; $display("FAIL rstx_cnt: got %h want %h", d, {16'(ref_cnt), 16'h0000}); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int wb, nw, last;
        for (int it = 0; it < 6; it++) begin
            vcount = 10'($urandom_range(520, 480));
            wb = wr_addr_q.size();
            last = -1;
            nw = $urandom_range(8, 0);
            for (int j = 0; j < nw; j++) begin
                last = $urandom_range(31, 0);
                cpu_write(6'(32 + last), $urandom);
            end
            if ($urandom_range(1, 0) == 1) cpu_write(6'h00, $urandom);
            cpu_write(6'h01, 32'h1);
            build_expected();
            wait_done(200, "rand");
            ref_cnt++;
            checks++;
            if (wr_addr_q.size() - wb != exp_addr_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d writes want %0d", it, wr_addr_q.size() - wb, exp_addr_q.size()); end
            for (int k = 0; k < exp_addr_q.size() && wb + k < wr_addr_q.size(); k++) begin
                checks++;
                if (wr_addr_q[wb + k] !== exp_addr_q[k] || wr_data_q[wb + k] !== exp_data_q[k]) begin
                    errors++; $display("FAIL rand%0d_wr%0d: got %h/%h want %h/%h", it, k, wr_addr_q[wb + k], wr_data_q[wb + k], exp_addr_q[k], exp_data_q[k]);
                end
            end
            if (last >= 0) begin
                cpu_read(6'(32 + last), d);
                checks++;
                if (d !== ref_shadow[last + 1]) begin errors++; $display("FAIL rand%0d_readback: got %h want %h", it, d, ref_shadow[last + 1]); end
            end
        end
        cpu_read(6'h05, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
        cpu_read(6'h01, d);
        checks++;
        if (d !== {16'(ref_cnt), 16'h0000}) begin errors++; $display("FAIL rand_cnt: got %h want %h", d, {16'(ref_cnt), 16'h0000}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_ctrl_only();
        test_window_edges();
        test_write_during_xfer();
        test_reset_mid_xfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
